// File: rtl/display_pkg.sv
// Shared types and helpers for the coffee-maker display arbiter: FSM states,
// source ids, the blank digit code and the fixed-priority encoder.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_e;

    localparam logic [3:0] BLANK    = 4'hF;
    localparam logic [1:0] SRC_ERR  = 2'd0;
    localparam logic [1:0] SRC_TMR  = 2'd1;
    localparam logic [1:0] SRC_STS  = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    // Lowest set index of req under mask wins; SRC_NONE when nothing qualifies.
    function automatic logic [1:0] pri_enc(input logic [2:0] req, input logic [2:0] mask);
        logic [2:0] m;
        m = req & mask;
        if (m[0]) begin
            pri_enc = SRC_ERR;
        end else if (m[1]) begin
            pri_enc = SRC_TMR;
        end else if (m[2]) begin
            pri_enc = SRC_STS;
        end else begin
            pri_enc = SRC_NONE;
        end
    endfunction

    function automatic logic [2:0] src_onehot(input logic [1:0] src);
        case (src)
            SRC_ERR: src_onehot = 3'b001;
            SRC_TMR: src_onehot = 3'b010;
            SRC_STS: src_onehot = 3'b100;
            default: src_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Combinational binary to two-digit BCD; inputs above 99 saturate to 99.
module bin2bcd99 (
    input  logic [7:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [6:0] clamped_s;

    // Clamp, then split into decimal tens and units.
    always_comb begin
        clamped_s = (bin_i > 8'd99) ? 7'd99 : bin_i[6:0];
        tens_o    = 4'(clamped_s / 7'd10);
        units_o   = 4'(clamped_s % 7'd10);
    end

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority arbiter with minimum dwell and anti-starvation rotation that
// shares one 4-digit seven-segment display between error, timer and status.
module display_arbiter
    import display_pkg::*;
#(
    parameter int SCAN_BITS = 17,
    parameter int DWELL     = 50_000_000,
    parameter int DWELL_W   = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] val0,
    input  logic [7:0] val1,
    input  logic [7:0] val2,
    output logic [2:0] gnt,
    output logic [3:0] digit,
    output logic [3:0] an
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    state_e               state_q, state_d;
    logic [2:0]           gnt_q, gnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [SCAN_BITS-1:0] psc_q, psc_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0]           an_q, an_d;
    logic [3:0]           digit_q, digit_d;
    logic                 lblank_q, lblank_d;
    logic [7:0]           lval_q, lval_d;
    logic [1:0]           lsrc_q, lsrc_d;

    logic [1:0] cur_src_s, higher_s, remain_s, other_s;
    logic [2:0] higher_mask_s;
    logic       held_s, dwell_done_s, boundary_s;
    logic [3:0] tens_s, units_s;

    // Arbitration: preemption beats release, release beats rotation.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        dwell_d   = dwell_q;
        cur_src_s = pri_enc(gnt_q, 3'b111);
        case (cur_src_s)
            SRC_TMR: higher_mask_s = 3'b001;
            SRC_STS: higher_mask_s = 3'b011;
            default: higher_mask_s = 3'b000;
        endcase
        higher_s     = pri_enc(req, higher_mask_s);
        remain_s     = pri_enc(req, 3'b111);
        other_s      = pri_enc(req, ~gnt_q);
        held_s       = |(req & gnt_q);
        dwell_done_s = (state_q == OPEN) || (dwell_q == DWELL_LAST);
        case (state_q)
            IDLE: begin
                if (remain_s != SRC_NONE) begin
                    gnt_d   = src_onehot(remain_s);
                    state_d = HOLD;
                    dwell_d = '0;
                end else begin
                    gnt_d   = 3'b000;
                end
            end
            HOLD, OPEN: begin
                if (higher_s != SRC_NONE) begin
                    gnt_d   = src_onehot(higher_s);
                    state_d = HOLD;
                    dwell_d = '0;
                end else if (!held_s) begin
                    gnt_d   = src_onehot(remain_s);
                    state_d = (remain_s != SRC_NONE) ? HOLD : IDLE;
                    dwell_d = '0;
                end else if (dwell_done_s) begin
                    // Dwell expiry and rotation share an edge so a waiting
                    // source takes over exactly DWELL cycles after the grant.
                    if (other_s != SRC_NONE) begin
                        gnt_d   = src_onehot(other_s);
                        state_d = HOLD;
                        dwell_d = '0;
                    end else begin
                        state_d = OPEN;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                dwell_d = '0;
            end
        endcase
    end

    // Scan prescaler, anode index, frame latch and registered digit mux.
    always_comb begin
        psc_d      = psc_q + SCAN_BITS'(1);
        idx_d      = (&psc_q) ? (idx_q + 2'd1) : idx_q;
        boundary_s = (&psc_q) && (idx_q == 2'd3);
        lblank_d   = lblank_q;
        lval_d     = lval_q;
        lsrc_d     = lsrc_q;
        if (boundary_s) begin
            lblank_d = (gnt_q == 3'b000);
            lsrc_d   = (cur_src_s == SRC_NONE) ? SRC_ERR : cur_src_s;
            case (gnt_q)
                3'b001:  lval_d = val0;
                3'b010:  lval_d = val1;
                3'b100:  lval_d = val2;
                default: lval_d = 8'd0;
            endcase
        end else begin
            lblank_d = lblank_q;
        end
        case (idx_d)
            2'd0:    an_d = 4'b1110;
            2'd1:    an_d = 4'b1101;
            2'd2:    an_d = 4'b1011;
            2'd3:    an_d = 4'b0111;
            default: an_d = 4'b1110;
        endcase
        if (lblank_d) begin
            digit_d = BLANK;
        end else begin
            case (idx_d)
                2'd0:    digit_d = units_s;
                2'd1:    digit_d = tens_s;
                2'd2:    digit_d = {2'b00, lsrc_d};
                default: digit_d = BLANK;
            endcase
        end
    end

    bin2bcd99 u_bcd (
        .bin_i   (lval_d),
        .tens_o  (tens_s),
        .units_o (units_s)
    );

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            dwell_q  <= '0;
            psc_q    <= '0;
            idx_q    <= 2'd0;
            an_q     <= 4'b1110;
            digit_q  <= BLANK;
            lblank_q <= 1'b1;
            lval_q   <= 8'd0;
            lsrc_q   <= SRC_ERR;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            dwell_q  <= dwell_d;
            psc_q    <= psc_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            digit_q  <= digit_d;
            lblank_q <= lblank_d;
            lval_q   <= lval_d;
            lsrc_q   <= lsrc_d;
        end
    end

    assign gnt   = gnt_q;
    assign digit = digit_q;
    assign an    = an_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_display_arbiter;

    localparam int SB    = 2;
    localparam int DW    = 8;
    localparam int FRAME = 4 * (1 << SB);

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] val0, val1, val2;
    logic [2:0] gnt;
    logic [3:0] digit, an;

    int errors = 0;
    int checks = 0;

    int         m_g, m_age, m_n, m_lval, m_lsrc;
    bit         m_lblank;
    logic [2:0] m_prev_req;
    bit         m_prev_rst;

    display_arbiter #(.SCAN_BITS(SB), .DWELL(DW), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .val0  (val0),
        .val1  (val1),
        .val2  (val2),
        .gnt   (gnt),
        .digit (digit),
        .an    (an)
    );

    always #5 clk = ~clk;

    function automatic int hi(input logic [2:0] m);
        for (int i = 0; i < 3; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int clampv(input logic [7:0] v);
        return (v > 8'd99) ? 99 : int'(v);
    endfunction

    function automatic logic [2:0] exp_gnt();
        return (m_g < 0) ? 3'b000 : (3'b001 << m_g);
    endfunction

    function automatic logic [3:0] exp_an();
        int i;
        i = (m_n / (1 << SB)) % 4;
        return 4'b1111 ^ (4'b0001 << i);
    endfunction

    function automatic logic [3:0] exp_digit();
        int i;
        i = (m_n / (1 << SB)) % 4;
        if (m_lblank) return 4'hF;
        case (i)
            0:       return 4'(m_lval % 10);
            1:       return 4'(m_lval / 10);
            2:       return 4'(m_lsrc);
            default: return 4'hF;
        endcase
    endfunction

    // One clock edge for DUT and model alike; samples land 1 time unit later.
    task automatic tick();
        logic [2:0] r, higher, others;
        bit         rs;
        int         v[3];
        int         g, ng;
        r = req; rs = rst; v[0] = int'(val0); v[1] = int'(val1); v[2] = int'(val2);
        @(posedge clk);
        if (rs) begin
            m_g = -1; m_age = 0; m_n = 0; m_lblank = 1'b1; m_lval = 0; m_lsrc = 0;
        end else begin
            g = m_g;
            if (((m_n + 1) % FRAME) == 0) begin
                m_lblank = (g < 0);
                if (g >= 0) begin
                    m_lval = clampv(8'(v[g]));
                    m_lsrc = g;
                end
            end
            ng = g;
            if (g < 0) begin
                ng = hi(r);
            end else begin
                higher = r & ((3'b001 << g) - 3'b001);
                others = r & ~(3'b001 << g);
                if (higher != 3'b000) ng = hi(higher);
                else if (r[g] == 1'b0) ng = hi(r);
                else if (m_age >= DW - 1 && others != 3'b000) ng = hi(others);
            end
            if (ng != g) m_age = 0;
            else if (g >= 0) m_age++;
            m_g = ng;
            m_n++;
        end
        m_prev_req = r;
        m_prev_rst = rs;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; val0 = 8'd12; val1 = 8'd34; val2 = 8'd56;
        repeat (3) tick();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b want=000", gnt); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b want=1110", an); end
        checks++; if (digit !== 4'hF) begin errors++; $display("FAIL reset_digit got=%h want=f", digit); end
        rst = 1'b0;
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL reset_release_gnt got=%b want=001", gnt); end
    endtask

    task automatic test_single();
        logic [3:0] want[4];
        want[0] = 4'd2; want[1] = 4'd4; want[2] = 4'd2; want[3] = 4'hF;
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b100; val2 = 8'd42;
        tick();
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL single_gnt got=%b want=100", gnt); end
        while ((m_n % FRAME) != 0) tick();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (digit !== want[k] || an !== (4'b1111 ^ (4'b0001 << k)))
                begin errors++; $display("FAIL single_scan k=%0d got=%h/%b want=%h", k, digit, an, want[k]); end
                repeat (1 << SB) tick();
            end
        end
    endtask

    task automatic test_preempt();
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b010;
        tick();
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL preempt_t got=%b want=010", gnt); end
        repeat (3) tick();
        req = 3'b011;
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL preempt_t4 got=%b want=001", gnt); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (gnt !== ((k == 8) ? 3'b010 : 3'b001))
            begin errors++; $display("FAIL preempt_dwell k=%0d got=%b", k, gnt); end
        end
    endtask

    task automatic test_rotation();
        logic [2:0] pat[2];
        pat[0] = 3'b011; pat[1] = 3'b110;
        for (int p = 0; p < 2; p++) begin
            rst = 1'b1; tick(); rst = 1'b0;
            req = pat[p];
            for (int c = 0; c < 40; c++) begin
                tick();
                checks++;
                if (gnt !== exp_gnt())
                begin errors++; $display("FAIL rotation p=%0d c=%0d got=%b want=%b", p, c, gnt, exp_gnt()); end
            end
        end
    endtask

    task automatic test_clamp();
        logic [3:0] want[8];
        want[0] = 4'd9; want[1] = 4'd9; want[2] = 4'd1; want[3] = 4'hF;
        want[4] = 4'd5; want[5] = 4'd0; want[6] = 4'd1; want[7] = 4'hF;
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b010; val1 = 8'd200;
        repeat (FRAME) tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (digit !== want[k]) begin errors++; $display("FAIL clamp_digit k=%0d got=%h want=%h", k, digit, want[k]); end
            if (k == 0) begin
                repeat (2) tick();
                val1 = 8'd5;
                repeat ((1 << SB) - 2) tick();
            end else begin
                repeat (1 << SB) tick();
            end
        end
    endtask

    task automatic test_release();
        req = 3'b001; val0 = 8'd77;
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL release_pre got=%b want=001", gnt); end
        req = 3'b000;
        tick();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL release_gnt got=%b want=000", gnt); end
        while ((m_n % FRAME) != 0) tick();
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (digit !== 4'hF) begin errors++; $display("FAIL release_blank c=%0d got=%h want=f", c, digit); end
            tick();
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) val0 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) val1 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) val2 = 8'($urandom_range(0, 255));
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (gnt !== exp_gnt() || an !== exp_an() || digit !== exp_digit())
            begin
                errors++;
                $display("FAIL random c=%0d got=%b/%b/%h want=%b/%b/%h", c, gnt, an, digit, exp_gnt(), exp_an(), exp_digit());
            end
            checks++;
            if ($countones(gnt) > 1 || (!m_prev_rst && (gnt & ~m_prev_req) != 3'b000))
            begin errors++; $display("FAIL random_guarantee c=%0d got=%b req=%b", c, gnt, m_prev_req); end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_g = -1; m_age = 0; m_n = 0; m_lblank = 1'b1; m_lval = 0; m_lsrc = 0;
        m_prev_req = 3'b000; m_prev_rst = 1'b1;
        rst = 1'b1; req = 3'b000; val0 = 8'd0; val1 = 8'd0; val2 = 8'd0;
        #2;
        test_reset();
        test_single();
        test_preempt();
        test_rotation();
        test_clamp();
        test_release();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
